id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the five-stage RISC-V core, placed directly downstream of the control decoder and register file. It captures the decoded control signals and operands each cycle and presents them to the EX stage. It also contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble. A branch flush also injects a bubble, and the block keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_stage_pkg.sv | 36 +++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Brief    : Shared encodings and the control-bundle type for the ID/EX stage.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
  localparam logic [6:0] STORE_TYPE  = 7'b0100011;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  localparam logic [1:0] R_OP     = 2'b10;
  localparam logic [1:0] B_OP     = 2'b01;
  localparam logic [1:0] OTHER_OP = 2'b00;

  localparam logic [1:0] REG = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] IMM = 2'd2;

  localparam logic [4:0] X0 = 5'd0;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use hazard check; a flush suppresses the stall.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       hazard,
  output logic       stall
);

  logic w_rd_match;

  // rs2 is checked regardless of format; an occasional spurious I-type stall is harmless
  assign w_rd_match = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hazard     = id_valid & ex_valid & ex_memread & (ex_rd != X0) & w_rd_match;
  assign stall      = hazard & ~flush;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use bubble insertion and a
//            saturating count of inserted bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic             id_branch_i,
  input  logic             id_memread_i,
  input  logic             id_memtoreg_i,
  input  logic             id_memwrite_i,
  input  logic             id_alusrc_i,
  input  logic             id_regwrite_i,
  input  logic [1:0]       id_aluop_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [9:0]       id_funct_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic             ex_branch_o,
  output logic             ex_memread_o,
  output logic             ex_memtoreg_o,
  output logic             ex_memwrite_o,
  output logic             ex_alusrc_o,
  output logic             ex_regwrite_o,
  output logic [1:0]       ex_aluop_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [9:0]       ex_funct_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [9:0]      r_funct;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [CNT_W-1:0] r_bubble_cnt;

  ctrl_t w_id_ctrl;
  logic  w_hazard;
  logic  w_stall;
  logic  w_bubble;
  logic  w_count;

  assign w_id_ctrl = '{branch:   id_branch_i,
                       memread:  id_memread_i,
                       memtoreg: id_memtoreg_i,
                       memwrite: id_memwrite_i,
                       alusrc:   id_alusrc_i,
                       regwrite: id_regwrite_i,
                       aluop:    id_aluop_i};

  load_use_detect u_load_use_detect (
    .ex_valid   (r_valid),
    .ex_memread (r_ctrl.memread),
    .ex_rd      (r_rd),
    .id_valid   (id_valid_i),
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .flush      (flush_i),
    .hazard     (w_hazard),
    .stall      (w_stall)
  );

  assign w_bubble = flush_i | w_hazard;
  // Flushing an empty slot discards nothing, so it is not counted
  assign w_count  = w_bubble & (id_valid_i | w_hazard);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_funct    <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_funct    <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      r_valid    <= id_valid_i;
      r_ctrl     <= w_id_ctrl;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_pc       <= id_pc_i;
      r_funct    <= id_funct_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_count && (r_bubble_cnt != C_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_o       = w_stall;
  assign ex_valid_o    = r_valid;
  assign ex_branch_o   = r_ctrl.branch;
  assign ex_memread_o  = r_ctrl.memread;
  assign ex_memtoreg_o = r_ctrl.memtoreg;
  assign ex_memwrite_o = r_ctrl.memwrite;
  assign ex_alusrc_o   = r_ctrl.alusrc;
  assign ex_regwrite_o = r_ctrl.regwrite;
  assign ex_aluop_o    = r_ctrl.aluop;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_pc_o       = r_pc;
  assign ex_funct_o    = r_funct;
  assign ex_rs1_o      = r_rs1;
  assign ex_rs2_o      = r_rs2;
  assign ex_rd_o       = r_rd;
  assign bubble_cnt_o  = r_bubble_cnt;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed bench for id_ex_stage with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  aluop;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ins_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic flush_i = 1'b0;
  ins_t id = '0;

  logic        stall_o, ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o;
  logic        ex_memwrite_o, ex_alusrc_o, ex_regwrite_o;
  logic [1:0]  ex_aluop_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [9:0]  ex_funct_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [15:0] bubble_cnt_o;

  logic        s_stall, s_valid, s_branch, s_memread, s_memtoreg, s_memwrite, s_alusrc, s_regwrite;
  logic [1:0]  s_aluop;
  logic [31:0] s_rs1d, s_rs2d, s_imm, s_pc;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad = 0;

  ins_t em;
  int   cnt_big;
  int   cnt_small;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id.valid),
    .id_branch_i(id.branch), .id_memread_i(id.memread), .id_memtoreg_i(id.memtoreg),
    .id_memwrite_i(id.memwrite), .id_alusrc_i(id.alusrc), .id_regwrite_i(id.regwrite),
    .id_aluop_i(id.aluop), .id_rs1_data_i(id.rs1d), .id_rs2_data_i(id.rs2d),
    .id_imm_i(id.imm), .id_pc_i(id.pc), .id_funct_i(id.funct),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_branch_o(ex_branch_o),
    .ex_memread_o(ex_memread_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_aluop_o(ex_aluop_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o), .ex_funct_o(ex_funct_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  // Narrow-counter copy fed the same stream; only its counter is observed
  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id.valid),
    .id_branch_i(id.branch), .id_memread_i(id.memread), .id_memtoreg_i(id.memtoreg),
    .id_memwrite_i(id.memwrite), .id_alusrc_i(id.alusrc), .id_regwrite_i(id.regwrite),
    .id_aluop_i(id.aluop), .id_rs1_data_i(id.rs1d), .id_rs2_data_i(id.rs2d),
    .id_imm_i(id.imm), .id_pc_i(id.pc), .id_funct_i(id.funct),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd), .flush_i(flush_i),
    .stall_o(s_stall), .ex_valid_o(s_valid), .ex_branch_o(s_branch),
    .ex_memread_o(s_memread), .ex_memtoreg_o(s_memtoreg),
    .ex_memwrite_o(s_memwrite), .ex_alusrc_o(s_alusrc),
    .ex_regwrite_o(s_regwrite), .ex_aluop_o(s_aluop),
    .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d),
    .ex_imm_o(s_imm), .ex_pc_o(s_pc), .ex_funct_o(s_funct),
    .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
    .bubble_cnt_o(s_cnt)
  );

  function automatic ins_t mk_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.valid = 1'b1; t.regwrite = 1'b1; t.aluop = 2'b10;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.rs1d = 32'h1000 + 32'(rs1); t.rs2d = 32'h2000 + 32'(rs2);
    t.pc = 32'h400 + {22'd0, rd, 5'd0};
    return t;
  endfunction

  function automatic ins_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.valid = 1'b1; t.memread = 1'b1; t.memtoreg = 1'b1; t.alusrc = 1'b1; t.regwrite = 1'b1;
    t.rd = rd; t.rs1 = rs1; t.rs2 = 5'd0; t.imm = 32'd16; t.funct = 10'b0000000_010;
    t.rs1d = 32'h3000 + 32'(rs1); t.pc = 32'h800 + {22'd0, rd, 5'd0};
    return t;
  endfunction

  function automatic ins_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.valid = 1'b1; t.memwrite = 1'b1; t.alusrc = 1'b1;
    t.rs1 = rs1; t.rs2 = rs2; t.imm = 32'd8; t.funct = 10'b0000000_010;
    return t;
  endfunction

  // Load-use rule stated at instruction level: a valid consumer reads the
  // non-zero destination of a load currently sitting in EX
  function automatic logic model_hazard(input ins_t ex, input ins_t dec);
    return dec.valid && ex.valid && ex.memread && ex.rd != 5'd0 &&
           (ex.rd == dec.rs1 || ex.rd == dec.rs2);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      em = '0; cnt_big = 0; cnt_small = 0;
    end else begin
      logic hz;
      hz = model_hazard(em, id);
      if ((flush_i || hz) && (id.valid || hz)) begin
        if (cnt_big < 65535) cnt_big = cnt_big + 1;
        if (cnt_small < 3) cnt_small = cnt_small + 1;
      end
      em = (flush_i || hz) ? '0 : id;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("stall", 64'(stall_o), 64'(model_hazard(em, id) && !flush_i));
    chk("valid", 64'(ex_valid_o), 64'(em.valid));
    chk("ctrl", 64'({ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o,
                     ex_alusrc_o, ex_regwrite_o, ex_aluop_o}),
                64'({em.branch, em.memread, em.memtoreg, em.memwrite,
                     em.alusrc, em.regwrite, em.aluop}));
    chk("data", {ex_rs1_data_o, ex_rs2_data_o}, {em.rs1d, em.rs2d});
    chk("imm_pc", {ex_imm_o, ex_pc_o}, {em.imm, em.pc});
    chk("fields", 64'({ex_funct_o, ex_rs1_o, ex_rs2_o, ex_rd_o}),
                  64'({em.funct, em.rs1, em.rs2, em.rd}));
    chk("cnt", 64'(bubble_cnt_o), 64'(cnt_big));
    chk("cnt_sat", 64'(s_cnt), 64'(cnt_small));
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    id = mk_add(5'd9, 5'd7, 5'd8);
    id.branch = 1'b1;
    repeat (3) step();
    chk("rst_valid", 64'(ex_valid_o), 64'd0);
    chk("rst_regwrite", 64'(ex_regwrite_o), 64'd0);
    chk("rst_pc", 64'(ex_pc_o), 64'd0);
    chk("rst_cnt", 64'(bubble_cnt_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);

    rst_i = 1'b1;
    id = mk_add(5'd3, 5'd1, 5'd2);
    step();
    chk("add_regwrite", 64'(ex_regwrite_o), 64'd1);
    chk("add_rd", 64'(ex_rd_o), 64'd3);
    chk("add_valid", 64'(ex_valid_o), 64'd1);
    chk("add_cnt", 64'(bubble_cnt_o), 64'd0);

    id = mk_lw(5'd5, 5'd1);
    step();
    id = mk_add(5'd6, 5'd5, 5'd1);
    #1 chk("lu_stall", 64'(stall_o), 64'd1);
    step();
    chk("lu_bubble_valid", 64'(ex_valid_o), 64'd0);
    chk("lu_bubble_memread", 64'(ex_memread_o), 64'd0);
    chk("lu_stall_clear", 64'(stall_o), 64'd0);
    step();
    chk("lu_add_rs1", 64'(ex_rs1_o), 64'd5);
    chk("lu_add_valid", 64'(ex_valid_o), 64'd1);
    chk("lu_cnt", 64'(bubble_cnt_o), 64'd1);

    id = mk_lw(5'd0, 5'd2);
    step();
    id = mk_add(5'd6, 5'd0, 5'd0);
    #1 chk("x0_no_stall", 64'(stall_o), 64'd0);
    step();
    id = mk_lw(5'd5, 5'd2);
    step();
    id = mk_add(5'd6, 5'd1, 5'd2);
    #1 chk("indep_no_stall", 64'(stall_o), 64'd0);
    step();

    id = mk_sw(5'd4, 5'd7);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_valid", 64'(ex_valid_o), 64'd0);
    chk("fl_memwrite", 64'(ex_memwrite_o), 64'd0);
    chk("fl_cnt", 64'(bubble_cnt_o), 64'd2);

    id = mk_lw(5'd5, 5'd1);
    step();
    id = mk_add(5'd6, 5'd5, 5'd1);
    flush_i = 1'b1;
    #1 chk("sim_stall", 64'(stall_o), 64'd0);
    step();
    flush_i = 1'b0;
    chk("sim_cnt", 64'(bubble_cnt_o), 64'd3);
    chk("sim_valid", 64'(ex_valid_o), 64'd0);

    id = mk_lw(5'd5, 5'd1);
    step();
    id = mk_lw(5'd6, 5'd5);
    step();
    step();
    id = mk_add(5'd7, 5'd2, 5'd6);
    #1 chk("b2b_stall2", 64'(stall_o), 64'd1);
    step();
    step();
    chk("b2b_cnt", 64'(bubble_cnt_o), 64'd5);

    id = '0;
    id.rd = 5'd12; id.rs1 = 5'd5; id.imm = 32'hdead;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("inval_flush_cnt", 64'(bubble_cnt_o), 64'd5);
    step();

    #2 rst_i = 1'b0;
    #1 chk("midrst_valid", 64'(ex_valid_o), 64'd0);
    chk("midrst_cnt", 64'(s_cnt), 64'd0);
    step();
    rst_i = 1'b1;
    id = mk_add(5'd10, 5'd11, 5'd12);
    flush_i = 1'b1;
    step();
    chk("sat1", 64'(s_cnt), 64'd1);
    step();
    chk("sat2", 64'(s_cnt), 64'd2);
    step();
    chk("sat3", 64'(s_cnt), 64'd3);
    step();
    chk("sat4", 64'(s_cnt), 64'd3);
    step();
    chk("sat5", 64'(s_cnt), 64'd3);
    chk("big_cnt", 64'(bubble_cnt_o), 64'd5);
    flush_i = 1'b0;
    step();
    chk("resume_rd", 64'(ex_rd_o), 64'd10);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
